// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b - bin), LSB first, start/busy/done handshake.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN; otherwise ovf is tied low.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a_sr;
  logic [W-1:0]    r_b_sr;
  logic [W-1:0]    r_res;
  logic            r_brw;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_diff;
  logic            r_bout;

  logic            w_accept;
  logic            w_last;
  logic            w_d;
  logic            w_brw_next;

  // DONE doubles as an accept cycle so a held start runs back-to-back.
  assign w_accept   = start && (r_state != S_SHIFT);
  assign w_last     = (r_state == S_SHIFT) && (r_count == CW'(W - 1));
  assign w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_brw;
  assign w_brw_next = (~r_a_sr[0] & r_b_sr[0]) | (~r_a_sr[0] & r_brw) | (r_b_sr[0] & r_brw);

  // NOTE: sequential state uses <= so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_brw   <= 1'b0;
      r_count <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_brw   <= bin;
      r_count <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_res   <= {w_d, r_res[W-1:1]};
      r_brw   <= w_brw_next;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_diff <= {w_d, r_res[W-1:1]};
        r_bout <= w_brw_next;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the last step a_sr[0]/b_sr[0] are the operand sign bits and d is the result sign.
  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_last) r_ovf <= (r_a_sr[0] ^ r_b_sr[0]) & (w_d ^ r_a_sr[0]);
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus randomized
// operations against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain modular / signed arithmetic.
  function automatic logic [W-1:0] ref_diff(input int ua, input int ub, input int ubin);
    int r;
    r = ua - ub - ubin;
    return W'(r);
  endfunction

  function automatic logic ref_bout(input int ua, input int ub, input int ubin);
    return (ua < ub + ubin);
  endfunction

  function automatic logic ref_ovf(input int ua, input int ub, input int ubin);
`ifdef SERIAL_SUB_OVF_EN
    int sa, sb, r;
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    r  = sa - sb - ubin;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one operation and observe cycles 0..W+3 after the accept edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       output int done_at, output int busy_cnt, output int done_cnt);
    done_at = -1; busy_cnt = 0; done_cnt = 0;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    step();
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    for (int c = 0; c < W + 4; c++) begin
      if (done && done_at < 0) done_at = c;
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      step();
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin);
    int done_at, busy_cnt, done_cnt;
    logic [W-1:0] e_diff;
    logic e_bout, e_ovf;
    e_diff = ref_diff(int'(ta), int'(tb), int'(tbin));
    e_bout = ref_bout(int'(ta), int'(tb), int'(tbin));
    e_ovf  = ref_ovf(int'(ta), int'(tb), int'(tbin));
    do_op(ta, tb, tbin, done_at, busy_cnt, done_cnt);
    checks++; if (done_at !== W) begin errors++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_at, W); end
    checks++; if (busy_cnt !== W) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_cnt, W); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses got %0d exp 1", name, done_cnt); end
    checks++; if (diff !== e_diff) begin errors++; $display("FAIL %s diff got %0d exp %0d", name, diff, e_diff); end
    checks++; if (bout !== e_bout) begin errors++; $display("FAIL %s bout got %0b exp %0b", name, bout, e_bout); end
    checks++; if (ovf !== e_ovf) begin errors++; $display("FAIL %s ovf got %0b exp %0b", name, ovf, e_ovf); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if ({busy, done, bout, ovf} !== 4'b0000) begin errors++; $display("FAIL reset flags got %b exp 0000", {busy, done, bout, ovf}); end
    checks++; if (diff !== '0) begin errors++; $display("FAIL reset diff got %0d exp 0", diff); end
  endtask

  task automatic test_directed();
    check_op("basic_100_37", 8'd100, 8'd37, 1'b0);
    checks++; if (diff !== 8'd63) begin errors++; $display("FAIL basic const diff got %0d exp 63", diff); end
    check_op("neg_5_9", 8'd5, 8'd9, 1'b0);
    checks++; if (diff !== 8'd252 || bout !== 1'b1) begin errors++; $display("FAIL neg const got %0d/%0b exp 252/1", diff, bout); end
    check_op("max_bin", 8'd255, 8'd255, 1'b1);
    checks++; if (diff !== 8'd255 || bout !== 1'b1) begin errors++; $display("FAIL max const got %0d/%0b exp 255/1", diff, bout); end
    check_op("zero", 8'd0, 8'd0, 1'b0);
    checks++; if (diff !== 8'd0 || bout !== 1'b0) begin errors++; $display("FAIL zero const got %0d/%0b exp 0/0", diff, bout); end
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0;
    a = 8'd10; b = 8'd3; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < W + 6; c++) begin
      done_cnt += int'(done);
      if (c == 3) begin a = 8'd200; b = 8'd1; start = 1'b1; end
      else begin start = 1'b0; a = '0; b = '0; end
      step();
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore done_pulses got %0d exp 1", done_cnt); end
    checks++; if (diff !== 8'd7 || bout !== 1'b0) begin errors++; $display("FAIL ignore result got %0d/%0b exp 7/0", diff, bout); end
  endtask

  task automatic test_back_to_back();
    int bad_busy = 0, bad_done = 0, bad_diff = 0;
    a = 8'd20; b = 8'd5; bin = 1'b0; start = 1'b1;
    step();
    for (int c = 0; c < 3 * (W + 1); c++) begin
      logic e_done;
      e_done = ((c % (W + 1)) == W);
      if (done !== e_done) bad_done++;
      if (busy !== !e_done) bad_busy++;
      if (e_done && diff !== 8'd15) bad_diff++;
      step();
    end
    start = 1'b0;
    checks++; if (bad_done !== 0) begin errors++; $display("FAIL b2b done_mismatches got %0d exp 0", bad_done); end
    checks++; if (bad_busy !== 0) begin errors++; $display("FAIL b2b busy_mismatches got %0d exp 0", bad_busy); end
    checks++; if (bad_diff !== 0) begin errors++; $display("FAIL b2b diff_mismatches got %0d exp 0", bad_diff); end
    repeat (W + 2) step();
  endtask

  task automatic test_mid_reset();
    int done_cnt = 0;
    a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({busy, done, bout} !== 3'b000 || diff !== '0) begin errors++; $display("FAIL midrst state got %b diff %0d exp 000 diff 0", {busy, done, bout}, diff); end
    for (int c = 0; c < 2 * W; c++) begin
      done_cnt += int'(done);
      step();
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst done_pulses got %0d exp 0", done_cnt); end
    check_op("after_rst", 8'd50, 8'd20, 1'b0);
  endtask

  task automatic test_ovf();
    check_op("ovf_80_01", 8'h80, 8'h01, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (diff !== 8'h7F || ovf !== 1'b1) begin errors++; $display("FAIL ovf const got %h/%0b exp 7f/1", diff, ovf); end
`else
    checks++; if (diff !== 8'h7F || ovf !== 1'b0) begin errors++; $display("FAIL ovf const got %h/%0b exp 7f/0", diff, ovf); end
`endif
    check_op("ovf_10_01", 8'h10, 8'h01, 1'b0);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL noovf const got %0b exp 0", ovf); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] ra, rb;
      logic rbin;
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom_range(1, 0));
      check_op($sformatf("rand%0d", i), ra, rb, rbin);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_ovf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
